// File: rtl/tlc_sensor_unit.sv
// Loop-detector conditioning for both approaches: synchronise, debounce, count
// waiting vehicles and discharge them while the approach has green.

module tlc_sensor_chan #(
  parameter int DB_CYCLES     = 16,
  parameter int DEPART_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             det_raw_i,
  input  logic             green_i,
  output logic             demand_o,
  output logic [CNT_W-1:0] queue_o,
  output logic             sat_o
);

  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam int DEP_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES);
  localparam logic [DEP_W-1:0] DEP_LAST = DEP_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_MAX    = '1;

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_e;

  logic [1:0]       sync_q;
  logic             det_s;
  db_state_e        state_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             arrive_q;
  logic [DEP_W-1:0] dep_cnt_q, dep_cnt_d;
  logic             count_en, depart;
  logic [CNT_W-1:0] queue_q, queue_d;
  logic             sat_q, sat_d;
  logic             demand_q;

  assign det_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], det_raw_i};
  end

  // A level change is accepted only after DB_CYCLES stable synced cycles;
  // only an accepted rise produces the one-cycle arrival pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_LOW;
      db_cnt_q <= '0;
      arrive_q <= 1'b0;
    end else begin
      arrive_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (det_s) begin
            state_q  <= S_RISE;
            db_cnt_q <= DB_W'(1);
          end
        end
        S_RISE: begin
          if (!det_s) begin
            state_q <= S_LOW;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= S_HIGH;
            arrive_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
        S_HIGH: begin
          if (!det_s) begin
            state_q  <= S_FALL;
            db_cnt_q <= DB_W'(1);
          end
        end
        S_FALL: begin
          if (det_s) begin
            state_q <= S_HIGH;
          end else if (db_cnt_q == DB_LAST) begin
            state_q <= S_LOW;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
        default: state_q <= S_LOW;
      endcase
    end
  end

  // The discharge timer only runs with green and a non-empty queue, so a
  // depart can never be issued against an empty queue.
  always_comb begin
    count_en  = green_i && (queue_q != '0);
    depart    = count_en && (dep_cnt_q == DEP_LAST);
    dep_cnt_d = '0;
    if (count_en && !depart) dep_cnt_d = dep_cnt_q + DEP_W'(1);
  end

  always_comb begin
    queue_d = queue_q;
    sat_d   = sat_q;
    if (arrive_q && !depart) begin
      if (queue_q == Q_MAX) sat_d = 1'b1;
      else                  queue_d = queue_q + CNT_W'(1);
    end else if (depart && !arrive_q) begin
      queue_d = queue_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dep_cnt_q <= '0;
      queue_q   <= '0;
      sat_q     <= 1'b0;
      demand_q  <= 1'b0;
    end else begin
      dep_cnt_q <= dep_cnt_d;
      queue_q   <= queue_d;
      sat_q     <= sat_d;
      demand_q  <= (queue_d != '0);
    end
  end

  assign demand_o = demand_q;
  assign queue_o  = queue_q;
  assign sat_o    = sat_q;

endmodule

module tlc_sensor_unit #(
  parameter int DB_CYCLES     = 16,
  parameter int DEPART_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             det_a_raw,
  input  logic             det_b_raw,
  input  logic             Ga,
  input  logic             Gb,
  output logic             Sa,
  output logic             Sb,
  output logic [CNT_W-1:0] queue_a,
  output logic [CNT_W-1:0] queue_b,
  output logic             sat_a,
  output logic             sat_b
);

  tlc_sensor_chan #(
    .DB_CYCLES(DB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES), .CNT_W(CNT_W)
  ) u_chan_a (
    .clk(clk), .reset_n(reset_n), .det_raw_i(det_a_raw), .green_i(Ga),
    .demand_o(Sa), .queue_o(queue_a), .sat_o(sat_a)
  );

  tlc_sensor_chan #(
    .DB_CYCLES(DB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES), .CNT_W(CNT_W)
  ) u_chan_b (
    .clk(clk), .reset_n(reset_n), .det_raw_i(det_b_raw), .green_i(Gb),
    .demand_o(Sb), .queue_o(queue_b), .sat_o(sat_b)
  );

endmodule

// File: tb/tb_tlc_sensor_unit.sv
// Self-checking bench for tlc_sensor_unit: expected queue/demand values are
// scheduled per cycle into a scoreboard and compared by a negedge monitor.

module tb_tlc_sensor_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       det_a_raw, det_b_raw, Ga, Gb;
  logic       Sa, Sb, sat_a, sat_b;
  logic [2:0] queue_a, queue_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    bit ch;
    int q;
    bit s;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  logic [7:0] monQ;
  logic monS;

  tlc_sensor_unit #(.DB_CYCLES(4), .DEPART_CYCLES(3), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .det_a_raw(det_a_raw), .det_b_raw(det_b_raw),
    .Ga(Ga), .Gb(Gb), .Sa(Sa), .Sb(Sb), .queue_a(queue_a), .queue_b(queue_b),
    .sat_a(sat_a), .sat_b(sat_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every entry is due at an exact cycle; late ones fail.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      monE = sb.pop_front();
      monQ = monE.ch ? {5'b0, queue_b} : {5'b0, queue_a};
      monS = monE.ch ? Sb : Sa;
      checks++;
      if (monE.cyc != cyc || monQ !== 8'(monE.q) || monS !== monE.s) begin
        errors++;
        $display("[TB] FAIL queue_%s cyc=%0d (due %0d): queue=%0d S=%b, required queue=%0d S=%b",
                 monE.ch ? "b" : "a", cyc, monE.cyc, monQ, monS, monE.q, monE.s);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void push_exp(int c, bit ch, int q);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    e.q   = q;
    e.s   = (q != 0);
    sb.push_back(e);
  endfunction

  task automatic set_raw(input bit ch, input logic v);
    if (ch) det_b_raw = v;
    else    det_a_raw = v;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    det_a_raw = 1'b0; det_b_raw = 1'b0; Ga = 1'b0; Gb = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One clean 20-cycle detector pulse; the queue moves 8 cycles after the rise.
  task automatic pulse_det(input bit ch, input int qBefore, input int qAfter);
    int c;
    @(negedge clk);
    c = cyc;
    set_raw(ch, 1'b1);
    push_exp(c + 7, ch, qBefore);
    push_exp(c + 8, ch, qAfter);
    repeat (10) @(negedge clk);
    set_raw(ch, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    int c;
    reset_n = 1'b0;
    det_a_raw = 1'b1; det_b_raw = 1'b0; Ga = 1'b0; Gb = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Sa, Sb, sat_a, sat_b, queue_a, queue_b} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, required all zero",
               {Sa, Sb, sat_a, sat_b, queue_a, queue_b});
    end
    c = cyc;
    reset_n = 1'b1;
    push_exp(c + 7, 1'b0, 0);
    push_exp(c + 8, 1'b0, 1);
    push_exp(c + 9, 1'b0, 1);
    push_exp(c + 9, 1'b1, 0);
    repeat (10) @(negedge clk);
    det_a_raw = 1'b0;
    push_exp(c + 18, 1'b0, 1);
    repeat (10) @(negedge clk);
    wait_drain();
  endtask

  task automatic test_glitch();
    int c;
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      c = cyc;
      det_b_raw = 1'b1;
      for (int k = 1; k <= w + 10; k++) push_exp(c + k, 1'b1, 0);
      repeat (w) @(negedge clk);
      det_b_raw = 1'b0;
      repeat (9) @(negedge clk);
    end
    wait_drain();
  endtask

  task automatic test_saturate();
    int c;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      c = cyc;
      det_a_raw = 1'b1;
      push_exp(c + 7, 1'b0, (k - 1 > 7) ? 7 : k - 1);
      push_exp(c + 8, 1'b0, (k > 7) ? 7 : k);
      repeat (10) @(negedge clk);
      checks++;
      if (sat_a !== (k == 8)) begin
        errors++;
        $display("[TB] FAIL sat_a after arrival %0d: got %b, required %b", k, sat_a, (k == 8));
      end
      det_a_raw = 1'b0;
      repeat (10) @(negedge clk);
    end
    wait_drain();
    checks++;
    if (sat_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_b independence: got %b, required 0", sat_b);
    end
  endtask

  task automatic test_discharge();
    int c, d;
    do_reset();
    pulse_det(1'b0, 0, 1);
    pulse_det(1'b0, 1, 2);
    @(negedge clk);
    c = cyc;
    Ga = 1'b1;
    push_exp(c + 2, 1'b0, 2);
    push_exp(c + 3, 1'b0, 2);
    repeat (2) @(negedge clk);
    Ga = 1'b0;
    repeat (2) @(negedge clk);
    d = cyc;
    Ga = 1'b1;
    push_exp(d + 2, 1'b0, 2);
    push_exp(d + 3, 1'b0, 1);
    push_exp(d + 5, 1'b0, 1);
    push_exp(d + 6, 1'b0, 0);
    push_exp(d + 9, 1'b0, 0);
    repeat (10) @(negedge clk);
    Ga = 1'b0;
    wait_drain();
  endtask

  task automatic test_arrive_depart();
    int c;
    do_reset();
    pulse_det(1'b0, 0, 1);
    @(negedge clk);
    c = cyc;
    det_a_raw = 1'b1;
    push_exp(c + 7, 1'b0, 1);
    push_exp(c + 8, 1'b0, 1);
    push_exp(c + 9, 1'b0, 1);
    push_exp(c + 12, 1'b0, 1);
    repeat (5) @(negedge clk);
    Ga = 1'b1;
    repeat (4) @(negedge clk);
    Ga = 1'b0;
    repeat (5) @(negedge clk);
    det_a_raw = 1'b0;
    repeat (10) @(negedge clk);
    wait_drain();
    checks++;
    if (sat_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_a on collision: got %b, required 0", sat_a);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    pulse_det(1'b1, 0, 1);
    pulse_det(1'b1, 1, 2);
    pulse_det(1'b1, 2, 3);
    wait_drain();
    @(negedge clk);
    det_b_raw = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (queue_b !== 3'd0 || Sb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: queue_b=%0d Sb=%b, required 0 0", queue_b, Sb);
    end
    @(negedge clk);
    c = cyc;
    reset_n = 1'b1;
    push_exp(c + 7, 1'b1, 0);
    push_exp(c + 8, 1'b1, 1);
    repeat (10) @(negedge clk);
    det_b_raw = 1'b0;
    repeat (10) @(negedge clk);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    @(negedge clk);
    c = cyc;
    det_a_raw = 1'b1;
    det_b_raw = 1'b1;
    push_exp(c + 8, 1'b0, 1);
    push_exp(c + 8, 1'b1, 1);
    repeat (10) @(negedge clk);
    c = cyc;
    Ga = 1'b1;
    Gb = 1'b1;
    push_exp(c + 2, 1'b0, 1);
    push_exp(c + 2, 1'b1, 1);
    push_exp(c + 3, 1'b0, 0);
    push_exp(c + 3, 1'b1, 0);
    repeat (5) @(negedge clk);
    Ga = 1'b0; Gb = 1'b0;
    det_a_raw = 1'b0; det_b_raw = 1'b0;
    repeat (10) @(negedge clk);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_saturate();
    test_discharge();
    test_arrive_depart();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
